// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one UART transmit path among NUM_REQ producers.
// Define UART_ARB_PRIO0_EN to give requester 0 strict priority over the round-robin group.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       tx_start,
  output logic [DATA_W-1:0]          tx_data,
  output logic [$clog2(NUM_REQ)-1:0] tx_owner,
  input  logic                       tx_done,
  output logic                       busy,
  output logic                       err
);
  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int WAIT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int GAP_W  = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_GAP} state_t;

  state_t              state_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic                tx_start_q;
  logic [DATA_W-1:0]   tx_data_q;
  logic [IDX_W-1:0]    tx_owner_q;
  logic                busy_q;
  logic                err_q;
  logic [IDX_W-1:0]    rr_ptr_q;
  logic [WAIT_W-1:0]   wait_cnt_q;
  logic [GAP_W-1:0]    gap_cnt_q;

  logic [NUM_REQ-1:0]  cand_d;
  logic [IDX_W-1:0]    scan_idx_d;
  logic [IDX_W-1:0]    win_idx_d;
  logic                win_found_d;
  logic                rr_upd_d;

  // Scan from the farthest slot back to rr_ptr+1 so the nearest asserted request wins.
  always_comb begin
    cand_d      = req;
    scan_idx_d  = '0;
    win_idx_d   = '0;
    win_found_d = 1'b0;
    rr_upd_d    = 1'b1;
`ifdef UART_ARB_PRIO0_EN
    cand_d[0] = 1'b0;
`endif
    for (int k = NUM_REQ; k >= 1; k--) begin
      scan_idx_d = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (cand_d[scan_idx_d]) begin
        win_found_d = 1'b1;
        win_idx_d   = scan_idx_d;
      end
    end
`ifdef UART_ARB_PRIO0_EN
    if (req[0]) begin
      win_found_d = 1'b1;
      win_idx_d   = '0;
      rr_upd_d    = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      tx_owner_q <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      rr_ptr_q   <= IDX_W'(NUM_REQ - 1);
      wait_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      gnt_q      <= '0;
      tx_start_q <= 1'b0;
      err_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (win_found_d) begin
            gnt_q      <= NUM_REQ'(1) << win_idx_d;
            tx_start_q <= 1'b1;
            tx_data_q  <= req_data[int'(win_idx_d)*DATA_W +: DATA_W];
            tx_owner_q <= win_idx_d;
            if (rr_upd_d) rr_ptr_q <= win_idx_d;
            busy_q     <= 1'b1;
            state_q    <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          wait_cnt_q <= '0;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          // A completed frame wins over a watchdog expiry in the same cycle.
          if (tx_done || (TIMEOUT_CYC > 0 && wait_cnt_q == WAIT_W'(TIMEOUT_CYC - 1))) begin
            err_q     <= ~tx_done;
            gap_cnt_q <= '0;
            if (GAP_CYC == 0) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_GAP;
            end
          end else if (wait_cnt_q != '1) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        S_GAP: begin
          if (gap_cnt_q == GAP_W'(GAP_CYC - 1)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt      = gnt_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign tx_owner = tx_owner_q;
  assign busy     = busy_q;
  assign err      = err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed vector table, directed sequences and a
// randomized run, all checked against a timestamp-based reference model.
module tb_uart_tx_arbiter;
  localparam int N = 4, DW = 8, GAP = 2, TMO = 16;
`ifdef UART_ARB_PRIO0_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [1:0]  tx_owner;
  logic        tx_done;
  logic        busy;
  logic        err;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .GAP_CYC(GAP), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .gnt(gnt),
    .tx_start(tx_start), .tx_data(tx_data), .tx_owner(tx_owner), .tx_done(tx_done),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Reference model: event timestamps instead of states.
  int         m_free_at;    // first cycle in which a request may be sampled
  int         m_launch_at;  // cycle carrying gnt/tx_start of the latest grant
  int         m_err_at;
  bit         m_waiting;    // frame launched, completion not yet seen
  int         m_owner;
  logic [7:0] m_data;
  int         m_rr;

  logic [3:0] s_gnt;
  logic       s_start, s_busy, s_err;
  logic [7:0] s_data;
  logic [1:0] s_owner;
  int         s_cyc;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic        done;
    logic [3:0]  gnt;
    logic        start;
    logic        busy;
    logic        err;
    logic [1:0]  owner;
    logic [7:0]  txd;
  } vec_t;
  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r);
    if (PRIO && r[0]) return 0;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (m_rr + k) % N;
      if (r[idx] && !(PRIO && idx == 0)) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_free_at   = cyc;
    m_launch_at = -100;
    m_err_at    = -100;
    m_waiting   = 1'b0;
    m_owner     = 0;
    m_data      = 8'h00;
    m_rr        = N - 1;
  endtask

  task automatic model_update(input logic [3:0] r, input logic [31:0] d, input logic dn);
    int w;
    if (m_waiting) begin
      if (cyc > m_launch_at && dn) begin
        m_waiting = 1'b0;
        m_free_at = cyc + 1 + GAP;
      end else if (cyc == m_launch_at + TMO) begin
        m_waiting = 1'b0;
        m_err_at  = cyc + 1;
        m_free_at = cyc + 1 + GAP;
      end
    end else if (cyc >= m_free_at && r != 4'b0000) begin
      w = pick(r);
      m_owner = w;
      m_data  = d[w*8 +: 8];
      if (!(PRIO && w == 0)) m_rr = w;
      m_launch_at = cyc + 1;
      m_waiting   = 1'b1;
      m_free_at   = 1 << 30;
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; req = '0; tx_done = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc += n;
    model_reset();
  endtask

  task automatic step(input logic [3:0] r, input logic [31:0] d, input logic dn);
    logic [3:0] e_gnt;
    req = r; req_data = d; tx_done = dn;
    @(negedge clk);
    s_gnt = gnt; s_start = tx_start; s_busy = busy; s_err = err;
    s_data = tx_data; s_owner = tx_owner; s_cyc = cyc;
    e_gnt = (cyc == m_launch_at) ? (4'b0001 << m_owner) : 4'b0000;
    chk("gnt", gnt, e_gnt);
    chk("tx_start", tx_start, cyc == m_launch_at);
    chk("busy", busy, m_waiting || cyc < m_free_at);
    chk("err", err, cyc == m_err_at);
    chk("tx_owner", tx_owner, m_owner);
    chk("tx_data", tx_data, m_data);
    if (s_start) $display("grant cyc=%0d owner=%0d data=%02h", cyc, s_owner, s_data);
    model_update(r, d, dn);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1);
  end

  initial begin
    int order[$];
    int st_cyc[$];
    int dn_cyc[$];
    int exp_order[9];
    int exp6[2];
    logic [3:0] r;
    logic dn;
    int l_cyc, e_cnt, e_cyc, idle_cyc, g3_cnt;

    // req, data, done | gnt, start, busy, err, owner, tx_data
    vecs[0]  = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00};
    vecs[1]  = '{4'b0010, 32'h3C5AA511, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00};
    vecs[2]  = '{4'b0010, 32'hFFFFFFFF, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b0, 2'd1, 8'hA5};
    vecs[3]  = '{4'b0000, 32'hFFFFFFFF, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd1, 8'hA5};
    vecs[4]  = '{4'b0000, 32'hFFFFFFFF, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd1, 8'hA5};
    vecs[5]  = '{4'b0000, 32'hFFFFFFFF, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd1, 8'hA5};
    vecs[6]  = '{4'b0000, 32'hFFFFFFFF, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd1, 8'hA5};
    vecs[7]  = '{4'b0000, 32'hFFFFFFFF, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd1, 8'hA5};
    vecs[8]  = '{4'b0000, 32'hFFFFFFFF, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 8'hA5};
    vecs[9]  = '{4'b0000, 32'hFFFFFFFF, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 8'hA5};
    vecs[10] = '{4'b0000, 32'hFFFFFFFF, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 8'hA5};
    if (PRIO) exp_order = '{0, 0, 0, 0, 0, 1, 2, 3, 1};
    else      exp_order = '{0, 1, 2, 3, 0, 1, 2, 3, 1};
    if (PRIO) exp6 = '{0, 0};
    else      exp6 = '{0, 1};

    req = '0; req_data = '0; tx_done = 1'b0; reset = 1'b1;

    // Reset state and single grant with busy tail.
    do_reset(3);
    for (int i = 0; i < 11; i++) begin
      step(vecs[i].req, vecs[i].data, vecs[i].done);
      chk("vec_gnt", s_gnt, vecs[i].gnt);
      chk("vec_start", s_start, vecs[i].start);
      chk("vec_busy", s_busy, vecs[i].busy);
      chk("vec_err", s_err, vecs[i].err);
      chk("vec_owner", s_owner, vecs[i].owner);
      chk("vec_data", s_data, vecs[i].txd);
    end

    // Reset while waiting for tx_done.
    do_reset(3);
    step(4'b0001, 32'h00000077, 1'b0);
    step(4'b0001, 32'h00000077, 1'b0);
    for (int i = 0; i < 3; i++) step(4'b0000, 32'h0, 1'b0);
    do_reset(1);
    step(4'b0000, 32'h0, 1'b0);
    chk("rst_wait_busy", s_busy, 1'b0);
    chk("rst_wait_start", s_start, 1'b0);
    chk("rst_wait_err", s_err, 1'b0);
    e_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(4'b0000, 32'h0, 1'b0);
      if (s_err) e_cnt++;
    end
    chk("rst_wait_no_err", e_cnt, 0);

    // All requesters held, transmitter answers 10 cycles after each start.
    do_reset(3);
    for (int i = 0; i < 600 && order.size() < 9; i++) begin
      r  = (order.size() < 5) ? 4'b1111 : 4'b1110;
      dn = (cyc == m_launch_at + 10);
      if (dn) dn_cyc.push_back(cyc);
      step(r, $urandom, dn);
      if (s_start) begin
        order.push_back(int'(s_owner));
        st_cyc.push_back(s_cyc);
      end
    end
    chk("rr_grant_count", order.size(), 9);
    for (int i = 0; i < 9 && i < order.size(); i++) chk("rr_order", order[i], exp_order[i]);
    for (int i = 1; i < 5 && i < st_cyc.size() && i <= dn_cyc.size(); i++)
      chk("rr_done_to_start", st_cyc[i] - dn_cyc[i-1], GAP + 2);

    // Watchdog abort.
    for (int i = 0; i < 80 && !(!m_waiting && cyc >= m_free_at); i++)
      step(4'b0000, 32'h0, cyc == m_launch_at + 3);
    l_cyc = -1; e_cnt = 0; e_cyc = -1; idle_cyc = -1;
    for (int i = 0; i < 30; i++) begin
      step((i == 0) ? 4'b0100 : 4'b0000, 32'h11C32233, 1'b0);
      if (s_start) l_cyc = s_cyc;
      if (s_err) begin e_cnt++; e_cyc = s_cyc; end
      if (!s_busy && l_cyc >= 0 && idle_cyc < 0) idle_cyc = s_cyc;
    end
    chk("wd_err_count", e_cnt, 1);
    chk("wd_err_latency", e_cyc - l_cyc, TMO + 1);
    chk("wd_idle_latency", idle_cyc - l_cyc, TMO + 1 + GAP);
    chk("wd_owner", s_owner, 2);
    for (int i = 0; i < 4; i++) begin
      step(4'b0000, 32'h0, i[0]);
      chk("wd_done_in_idle", s_busy, 1'b0);
    end

    // Withdrawal: req[3] drops before it can be granted.
    do_reset(2);
    order.delete();
    g3_cnt = 0;
    step(4'b1001, 32'h44000055, 1'b0);
    step(4'b1001, 32'h44000055, 1'b0);
    if (s_start) order.push_back(int'(s_owner));
    for (int i = 0; i < 60 && order.size() < 2; i++) begin
      step(4'b0011, 32'h00006600 | 32'h55, cyc == m_launch_at + 5);
      if (s_gnt[3]) g3_cnt++;
      if (s_start) order.push_back(int'(s_owner));
    end
    chk("wdraw_no_gnt3", g3_cnt, 0);
    chk("wdraw_grant_count", order.size(), 2);
    for (int i = 0; i < 2 && i < order.size(); i++) chk("wdraw_order", order[i], exp6[i]);

    // Randomized traffic with occasional resets.
    r = 4'b0000;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset(1 + $urandom_range(0, 2));
      end else begin
        if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
        step(r, $urandom, $urandom_range(0, 7) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
